// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder/loader: packs symbolic op descriptors into 32-bit
// words and streams them to consecutive instruction-memory addresses.
module rv32i_instr_encoder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [5:0]            op_kind,
  input  logic [4:0]            op_rd,
  input  logic [4:0]            op_rs1,
  input  logic [4:0]            op_rs2,
  input  logic [31:0]           op_imm,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  done,
  output logic                  err_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;

  localparam logic [ADDR_WIDTH:0] LAST_PTR = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  function automatic logic [31:0] encode(input logic [5:0]  kind,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rs2,
                                         input logic [31:0] imm);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] w;
    f3 = 3'b000;
    f7 = 7'b0000000;
    w  = 32'h0;
    if (kind == 6'd0) begin
      w = {imm[31:12], rd, OPC_LUI};
    end else if (kind == 6'd1) begin
      w = {imm[31:12], rd, OPC_AUIPC};
    end else if (kind == 6'd2) begin
      w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
    end else if (kind == 6'd3) begin
      w = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
    end else if (kind <= 6'd9) begin
      case (kind)
        6'd4:    f3 = 3'd0;
        6'd5:    f3 = 3'd1;
        6'd6:    f3 = 3'd4;
        6'd7:    f3 = 3'd5;
        6'd8:    f3 = 3'd6;
        default: f3 = 3'd7;
      endcase
      w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
    end else if (kind <= 6'd14) begin
      case (kind)
        6'd10:   f3 = 3'd0;
        6'd11:   f3 = 3'd1;
        6'd12:   f3 = 3'd2;
        6'd13:   f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
      w = {imm[11:0], rs1, f3, rd, OPC_LOAD};
    end else if (kind <= 6'd17) begin
      case (kind)
        6'd15:   f3 = 3'd0;
        6'd16:   f3 = 3'd1;
        default: f3 = 3'd2;
      endcase
      w = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    end else if (kind <= 6'd23) begin
      case (kind)
        6'd18:   f3 = 3'd0;
        6'd19:   f3 = 3'd2;
        6'd20:   f3 = 3'd3;
        6'd21:   f3 = 3'd4;
        6'd22:   f3 = 3'd6;
        default: f3 = 3'd7;
      endcase
      w = {imm[11:0], rs1, f3, rd, OPC_OPIMM};
    end else if (kind <= 6'd26) begin
      // Shift-immediates carry only a 5-bit shamt; SRAI flags itself in funct7.
      f3 = (kind == 6'd24) ? 3'd1 : 3'd5;
      f7 = (kind == 6'd26) ? F7_ALT : 7'b0000000;
      w  = {f7, imm[4:0], rs1, f3, rd, OPC_OPIMM};
    end else if (kind <= 6'd36) begin
      case (kind)
        6'd27:   f3 = 3'd0;
        6'd28:   f3 = 3'd0;
        6'd29:   f3 = 3'd1;
        6'd30:   f3 = 3'd2;
        6'd31:   f3 = 3'd3;
        6'd32:   f3 = 3'd4;
        6'd33:   f3 = 3'd5;
        6'd34:   f3 = 3'd5;
        6'd35:   f3 = 3'd6;
        default: f3 = 3'd7;
      endcase
      f7 = (kind == 6'd28 || kind == 6'd34) ? F7_ALT : 7'b0000000;
      w  = {f7, rs2, rs1, f3, rd, OPC_OP};
    end
    return w;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic        accept;
  logic        legal;
  logic [31:0] word;

  assign op_ready = (state_q == S_RUN) && !finish && !last_q;
  assign accept   = op_valid && op_ready;
  assign legal    = (op_kind <= 6'd36);
  assign word     = encode(op_kind, op_rd, op_rs1, op_rs2, op_imm);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    err_d   = err_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          ptr_d   = '0;
          last_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (finish) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (accept) begin
          if (legal) begin
            we_d  = 1'b1;
            ptr_d = ptr_q + PTR_ONE;
            // The final slot closes input; no wrap back to address 0.
            if (ptr_q == LAST_PTR) begin
              last_d  = 1'b1;
              state_d = S_FULL;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FULL: begin
        if (finish) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      done_q  <= done_d;
      we_q    <= we_d;
      if (we_d) begin
        addr_q  <= ptr_q[ADDR_WIDTH-1:0];
        wdata_q <= word;
      end
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign count       = ptr_q;
  assign done        = done_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed bench for rv32i_instr_encoder: a default-size instance plus a
// 4-word instance sharing the same stimulus for the capacity-limit scenario.
module tb_rv32i_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic        op_valid = 1'b0;
  logic [5:0]  op_kind = '0;
  logic [4:0]  op_rd = '0;
  logic [4:0]  op_rs1 = '0;
  logic [4:0]  op_rs2 = '0;
  logic [31:0] op_imm = '0;

  logic        op_ready, imem_we, done, err_illegal;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] count;

  logic        s_op_ready, s_imem_we, s_done, s_err_illegal;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata;
  logic [2:0]  s_count;

  int total = 0;
  int bad = 0;

  rv32i_instr_encoder #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind),
    .op_rd(op_rd), .op_rs1(op_rs1), .op_rs2(op_rs2), .op_imm(op_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .done(done), .err_illegal(err_illegal)
  );

  rv32i_instr_encoder #(.ADDR_WIDTH(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .op_valid(op_valid), .op_ready(s_op_ready), .op_kind(op_kind),
    .op_rd(op_rd), .op_rs1(op_rs1), .op_rs2(op_rs2), .op_imm(op_imm),
    .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
    .count(s_count), .done(s_done), .err_illegal(s_err_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [5:0] k, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
    op_valid = 1'b1;
    op_kind  = k;
    op_rd    = rd;
    op_rs1   = rs1;
    op_rs2   = rs2;
    op_imm   = imm;
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_session();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({op_ready, imem_we, imem_addr, imem_wdata, count, done, err_illegal} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%0b we=%0b addr=%0d wdata=%h count=%0d done=%0b err=%0b, all required 0",
               op_ready, imem_we, imem_addr, imem_wdata, count, done, err_illegal);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (op_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_ready: got %0b want 0", op_ready);
    end
  endtask

  task automatic test_addi();
    start_session();
    total++;
    if (op_ready !== 1'b1 || count !== 11'd0) begin
      bad++;
      $display("FAIL run_entry: ready=%0b count=%0d want ready=1 count=0", op_ready, count);
    end
    set_op(6'd18, 5'd1, 5'd2, 5'd0, 32'd5);
    tick();
    op_valid = 1'b0;
    total++;
    if ({imem_we, imem_addr, imem_wdata, count} !== {1'b1, 10'd0, 32'h00510093, 11'd1}) begin
      bad++;
      $display("FAIL addi_write: we=%0b addr=%0d data=%h count=%0d want 1/0/00510093/1",
               imem_we, imem_addr, imem_wdata, count);
    end
    tick();
    total++;
    if (imem_we !== 1'b0) begin
      bad++;
      $display("FAIL addi_single_strobe: we=%0b want 0", imem_we);
    end
    end_session();
  endtask

  task automatic test_back_to_back();
    start_session();
    set_op(6'd28, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    total++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd0, 32'h402081B3}) begin
      bad++;
      $display("FAIL sub_write: we=%0b addr=%0d data=%h want 1/0/402081b3", imem_we, imem_addr, imem_wdata);
    end
    set_op(6'd4, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    tick();
    op_valid = 1'b0;
    total++;
    if ({imem_we, imem_addr, imem_wdata, count} !== {1'b1, 10'd1, 32'hFE208EE3, 11'd2}) begin
      bad++;
      $display("FAIL beq_write: we=%0b addr=%0d data=%h count=%0d want 1/1/fe208ee3/2",
               imem_we, imem_addr, imem_wdata, count);
    end
    end_session();
  endtask

  task automatic test_formats();
    logic [5:0]  k[7]   = '{6'd0, 6'd2, 6'd26, 6'd17, 6'd12, 6'd18, 6'd23};
    logic [4:0]  rd[7]  = '{5'd5, 5'd1, 5'd1, 5'd0, 5'd3, 5'd1, 5'd1};
    logic [4:0]  rs1[7] = '{5'd0, 5'd0, 5'd2, 5'd1, 5'd1, 5'd2, 5'd1};
    logic [4:0]  rs2[7] = '{5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0};
    logic [31:0] im[7]  = '{32'h12345000, 32'd8, 32'd3, 32'd8, 32'hFFFF_FFFC, 32'h0000_1005, 32'h0000_00FF};
    logic [31:0] ex[7]  = '{32'h123452B7, 32'h008000EF, 32'h40315093, 32'h0020A423,
                            32'hFFC0A183, 32'h00510093, 32'h0FF0F093};
    start_session();
    for (int i = 0; i < 7; i++) begin
      set_op(k[i], rd[i], rs1[i], rs2[i], im[i]);
      tick();
      total++;
      if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'(i), ex[i]}) begin
        bad++;
        $display("FAIL format_%0d: we=%0b addr=%0d data=%h want 1/%0d/%h",
                 i, imem_we, imem_addr, imem_wdata, i, ex[i]);
      end
    end
    op_valid = 1'b0;
    end_session();
  endtask

  task automatic test_illegal();
    start_session();
    set_op(6'd18, 5'd1, 5'd2, 5'd0, 32'd5);
    tick();
    set_op(6'd40, 5'd1, 5'd2, 5'd3, 32'd7);
    tick();
    total++;
    if ({imem_we, err_illegal, count} !== {1'b0, 1'b1, 11'd1}) begin
      bad++;
      $display("FAIL illegal_op: we=%0b err=%0b count=%0d want 0/1/1", imem_we, err_illegal, count);
    end
    set_op(6'd18, 5'd2, 5'd0, 5'd0, 32'd1);
    tick();
    op_valid = 1'b0;
    total++;
    if ({imem_we, imem_addr, imem_wdata, count, err_illegal} !== {1'b1, 10'd1, 32'h00100113, 11'd2, 1'b1}) begin
      bad++;
      $display("FAIL after_illegal: we=%0b addr=%0d data=%h count=%0d err=%0b want 1/1/00100113/2/1",
               imem_we, imem_addr, imem_wdata, count, err_illegal);
    end
    end_session();
    total++;
    if (err_illegal !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: err=%0b want 1", err_illegal);
    end
    start_session();
    total++;
    if (err_illegal !== 1'b0) begin
      bad++;
      $display("FAIL err_clear_on_start: err=%0b want 0", err_illegal);
    end
    end_session();
  endtask

  task automatic test_full();
    start_session();
    set_op(6'd18, 5'd1, 5'd2, 5'd0, 32'd5);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (s_op_ready !== 1'b1) begin
        bad++;
        $display("FAIL full_ready_%0d: ready=%0b want 1", i, s_op_ready);
      end
      tick();
      total++;
      if ({s_imem_we, s_imem_addr} !== {1'b1, 2'(i)}) begin
        bad++;
        $display("FAIL full_write_%0d: we=%0b addr=%0d want 1/%0d", i, s_imem_we, s_imem_addr, i);
      end
    end
    total++;
    if ({s_op_ready, s_count, op_ready} !== {1'b0, 3'd4, 1'b1}) begin
      bad++;
      $display("FAIL full_stop: small ready=%0b count=%0d, large ready=%0b want 0/4/1",
               s_op_ready, s_count, op_ready);
    end
    tick();
    op_valid = 1'b0;
    total++;
    if ({s_imem_we, s_count} !== {1'b0, 3'd4}) begin
      bad++;
      $display("FAIL full_no_wrap: we=%0b count=%0d want 0/4", s_imem_we, s_count);
    end
    start_session();
    total++;
    if ({s_op_ready, s_count} !== {1'b0, 3'd4}) begin
      bad++;
      $display("FAIL full_start_ignored: ready=%0b count=%0d want 0/4", s_op_ready, s_count);
    end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    total++;
    if (s_done !== 1'b1) begin
      bad++;
      $display("FAIL full_done: done=%0b want 1", s_done);
    end
    tick();
    total++;
    if ({s_done, s_op_ready} !== 2'b00) begin
      bad++;
      $display("FAIL full_idle: done=%0b ready=%0b want 0/0", s_done, s_op_ready);
    end
    start_session();
    total++;
    if ({s_op_ready, s_count} !== {1'b1, 3'd0}) begin
      bad++;
      $display("FAIL full_restart: ready=%0b count=%0d want 1/0", s_op_ready, s_count);
    end
    end_session();
  endtask

  task automatic test_finish_with_valid();
    start_session();
    set_op(6'd18, 5'd1, 5'd2, 5'd0, 32'd5);
    finish = 1'b1;
    #1;
    total++;
    if (op_ready !== 1'b0) begin
      bad++;
      $display("FAIL finish_blocks_ready: ready=%0b want 0", op_ready);
    end
    tick();
    finish = 1'b0;
    op_valid = 1'b0;
    total++;
    if ({done, imem_we, count} !== {1'b1, 1'b0, 11'd0}) begin
      bad++;
      $display("FAIL finish_with_valid: done=%0b we=%0b count=%0d want 1/0/0", done, imem_we, count);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_one_cycle: done=%0b want 0", done);
    end
  endtask

  task automatic test_reset_abort();
    start_session();
    set_op(6'd40, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    set_op(6'd18, 5'd1, 5'd2, 5'd0, 32'd5);
    tick();
    op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({op_ready, imem_we, imem_addr, imem_wdata, count, done, err_illegal} !== '0) begin
      bad++;
      $display("FAIL reset_abort: ready=%0b we=%0b addr=%0d wdata=%h count=%0d done=%0b err=%0b, all required 0",
               op_ready, imem_we, imem_addr, imem_wdata, count, done, err_illegal);
    end
    tick();
    total++;
    if (imem_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort_no_write: we=%0b want 0", imem_we);
    end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_formats();
    test_illegal();
    test_full();
    test_finish_with_valid();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
